// File: rtl/branch_unit_pkg.sv
// Shared types and constants for the branch unit: FSM states, target-calculation
// modes, register indices and default pipeline offsets.
package branch_unit_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD_PC,
      S_WAIT_PC,
      S_WR_LR,
      S_RD_RM,
      S_WAIT_RM,
      S_WR_PC,
      S_DONE
   } state_t;

   typedef enum logic [1:0] {
      MODE_BRANCH,
      MODE_EXCHANGE,
      MODE_NOT_TAKEN
   } mode_t;

   localparam logic [3:0] REG_LR = 4'd14;
   localparam logic [3:0] REG_PC = 4'd15;

   localparam int DEF_PC_AHEAD    = 8;
   localparam int DEF_INSTR_BYTES = 4;

endpackage

// File: rtl/branch_unit_if.sv
// Sequencer handshake plus register-file read/write ports of the branch unit.
// The unit itself uses the slave modport.
interface branch_unit_if #(
   parameter int ADDR_W = 32
);
   logic              en;
   logic              cond;
   logic              link;
   logic              exchange;
   logic [23:0]       offset;
   logic [3:0]        rm;
   logic              busy;
   logic              done;
   logic              thumb_set_en;
   logic              thumb_value;
   logic              read_en;
   logic [3:0]        read_reg;
   logic [ADDR_W-1:0] read_value;
   logic              write_en;
   logic [3:0]        write_reg;
   logic [ADDR_W-1:0] write_value;
   logic              write_restore_from_SPSR;

   modport slave (
      input  en, cond, link, exchange, offset, rm, read_value,
      output busy, done, thumb_set_en, thumb_value, read_en, read_reg,
             write_en, write_reg, write_value, write_restore_from_SPSR
   );

   modport master (
      output en, cond, link, exchange, offset, rm, read_value,
      input  busy, done, thumb_set_en, thumb_value, read_en, read_reg,
             write_en, write_reg, write_value, write_restore_from_SPSR
   );
endinterface

// File: rtl/branch_unit_target_calc.sv
// Combinational branch target and return-address computation.
// Offset arithmetic wraps modulo 2^ADDR_W.
module branch_target_calc
   import branch_unit_pkg::*;
#(
   parameter int ADDR_W      = 32,
   parameter int PC_AHEAD    = DEF_PC_AHEAD,
   parameter int INSTR_BYTES = DEF_INSTR_BYTES
) (
   input  logic [ADDR_W-1:0] pc,
   input  logic [ADDR_W-1:0] rm_value,
   input  logic [23:0]       offset,
   input  mode_t             mode,
   output logic [ADDR_W-1:0] target,
   output logic [ADDR_W-1:0] link_value
);
   logic [ADDR_W-1:0] off_ext;

   always_comb begin
      off_ext    = ADDR_W'($signed(offset));
      link_value = pc + ADDR_W'(INSTR_BYTES);
      case (mode)
         MODE_EXCHANGE:  target = {rm_value[ADDR_W-1:1], 1'b0};
         MODE_NOT_TAKEN: target = link_value;
         default:        target = pc + ADDR_W'(PC_AHEAD) + (off_ext << 2);
      endcase
   end
endmodule

// File: rtl/branch_unit.sv
// Multi-cycle executor for B, BL, BX and BLX(register) sharing the register-file
// ports; all handshake and register-file outputs come straight from flops.
module branch_unit
   import branch_unit_pkg::*;
#(
   parameter int ADDR_W      = 32,
   parameter int READ_LAT    = 1,
   parameter int PC_AHEAD    = DEF_PC_AHEAD,
   parameter int INSTR_BYTES = DEF_INSTR_BYTES,
   parameter int EXCHANGE_EN = 1
) (
   input  logic         clk,
   input  logic         rst,
   branch_unit_if.slave bus
);
   state_t            state_reg;
   logic              cond_q, link_q, exch_q;
   logic [23:0]       offset_q;
   logic [3:0]        rm_idx_q;
   logic [ADDR_W-1:0] pc_q;
   logic [2:0]        lat_cnt_reg;
   logic              lat_done;

   logic              busy_reg, done_reg, read_en_reg, write_en_reg;
   logic              thumb_set_en_reg, thumb_value_reg;
   logic [3:0]        read_idx_reg, write_idx_reg;
   logic [ADDR_W-1:0] write_value_reg;

   mode_t             calc_mode;
   logic [ADDR_W-1:0] calc_pc, calc_target, calc_link;

   assign lat_done = (lat_cnt_reg == 3'(READ_LAT - 1));

   // The PC is consumed on the same edge it is latched, so bypass pc_q then.
   always_comb begin
      calc_pc   = (state_reg == S_WAIT_PC) ? bus.read_value : pc_q;
      calc_mode = !cond_q ? MODE_NOT_TAKEN
                : ((state_reg == S_WAIT_RM) ? MODE_EXCHANGE : MODE_BRANCH);
   end

   branch_target_calc #(
      .ADDR_W      (ADDR_W),
      .PC_AHEAD    (PC_AHEAD),
      .INSTR_BYTES (INSTR_BYTES)
   ) u_calc (
      .pc         (calc_pc),
      .rm_value   (bus.read_value),
      .offset     (offset_q),
      .mode       (calc_mode),
      .target     (calc_target),
      .link_value (calc_link)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg        <= S_IDLE;
         cond_q           <= 1'b0;
         link_q           <= 1'b0;
         exch_q           <= 1'b0;
         offset_q         <= '0;
         rm_idx_q         <= '0;
         pc_q             <= '0;
         lat_cnt_reg      <= '0;
         busy_reg         <= 1'b0;
         done_reg         <= 1'b0;
         read_en_reg      <= 1'b0;
         read_idx_reg     <= '0;
         write_en_reg     <= 1'b0;
         write_idx_reg    <= '0;
         write_value_reg  <= '0;
         thumb_set_en_reg <= 1'b0;
         thumb_value_reg  <= 1'b0;
      end else begin
         read_en_reg      <= 1'b0;
         write_en_reg     <= 1'b0;
         done_reg         <= 1'b0;
         thumb_set_en_reg <= 1'b0;
         thumb_value_reg  <= 1'b0;
         case (state_reg)
            S_IDLE: if (bus.en) begin
               cond_q       <= bus.cond;
               link_q       <= bus.link;
               exch_q       <= bus.exchange & (EXCHANGE_EN != 0);
               offset_q     <= bus.offset;
               rm_idx_q     <= bus.rm;
               busy_reg     <= 1'b1;
               read_en_reg  <= 1'b1;
               read_idx_reg <= REG_PC;
               state_reg    <= S_RD_PC;
            end
            S_RD_PC: begin
               lat_cnt_reg <= '0;
               state_reg   <= S_WAIT_PC;
            end
            S_WAIT_PC: if (lat_done) begin
               pc_q <= bus.read_value;
               // A failed condition only steps the PC past the instruction.
               if (!cond_q || !(link_q || exch_q)) begin
                  write_en_reg    <= 1'b1;
                  write_idx_reg   <= REG_PC;
                  write_value_reg <= calc_target;
                  state_reg       <= S_WR_PC;
               end else if (link_q) begin
                  write_en_reg    <= 1'b1;
                  write_idx_reg   <= REG_LR;
                  write_value_reg <= calc_link;
                  state_reg       <= S_WR_LR;
               end else begin
                  read_en_reg  <= 1'b1;
                  read_idx_reg <= rm_idx_q;
                  state_reg    <= S_RD_RM;
               end
            end else begin
               lat_cnt_reg <= lat_cnt_reg + 3'd1;
            end
            S_WR_LR: if (exch_q) begin
               read_en_reg  <= 1'b1;
               read_idx_reg <= rm_idx_q;
               state_reg    <= S_RD_RM;
            end else begin
               write_en_reg    <= 1'b1;
               write_idx_reg   <= REG_PC;
               write_value_reg <= calc_target;
               state_reg       <= S_WR_PC;
            end
            S_RD_RM: begin
               lat_cnt_reg <= '0;
               state_reg   <= S_WAIT_RM;
            end
            S_WAIT_RM: if (lat_done) begin
               write_en_reg     <= 1'b1;
               write_idx_reg    <= REG_PC;
               write_value_reg  <= calc_target;
               thumb_set_en_reg <= 1'b1;
               thumb_value_reg  <= bus.read_value[0];
               state_reg        <= S_WR_PC;
            end else begin
               lat_cnt_reg <= lat_cnt_reg + 3'd1;
            end
            S_WR_PC: begin
               done_reg  <= 1'b1;
               state_reg <= S_DONE;
            end
            S_DONE: begin
               busy_reg  <= 1'b0;
               state_reg <= S_IDLE;
            end
            default: begin
               busy_reg  <= 1'b0;
               state_reg <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.busy                    = busy_reg;
   assign bus.done                    = done_reg;
   assign bus.read_en                 = read_en_reg;
   assign bus.read_reg                = read_idx_reg;
   assign bus.write_en                = write_en_reg;
   assign bus.write_reg               = write_idx_reg;
   assign bus.write_value             = write_value_reg;
   assign bus.thumb_set_en            = thumb_set_en_reg;
   assign bus.thumb_value             = thumb_value_reg;
   assign bus.write_restore_from_SPSR = 1'b0;
endmodule

// File: tb/tb_branch_unit.sv
// Scoreboard bench: two branch units (READ_LAT 1 and 3) against a register-file
// model; expected writes, T-bit pulses and done latencies are queued per unit.
module tb_branch_unit;
   localparam int K_WR = 0;
   localparam int K_TH = 1;
   localparam int K_DN = 2;

   typedef struct {
      int          kind;
      logic [3:0]  idx;
      logic [31:0] val;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_tests = 0;
   int   n_fail = 0;
   int   start_cyc [2];
   exp_t exp_q0 [$];
   exp_t exp_q1 [$];

   logic        pre_we [2];
   logic [3:0]  pre_idx;
   logic [31:0] pre_val;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   branch_unit_if #(.ADDR_W(32)) bif0 ();
   branch_unit_if #(.ADDR_W(32)) bif1 ();

   branch_unit #(.ADDR_W(32), .READ_LAT(1)) u_dut0 (.clk(clk), .rst(rst), .bus(bif0));
   branch_unit #(.ADDR_W(32), .READ_LAT(3)) u_dut1 (.clk(clk), .rst(rst), .bus(bif1));

   // Register files: reads return garbage unless requested READ_LAT cycles earlier.
   logic [31:0] rf0 [16];
   logic [31:0] rf1 [16];
   logic [31:0] rd0;
   logic [31:0] rd1 [3];

   always @(posedge clk) begin
      if (pre_we[0]) rf0[pre_idx] <= pre_val;
      else if (bif0.write_en) rf0[bif0.write_reg] <= bif0.write_value;
      rd0 <= bif0.read_en ? rf0[bif0.read_reg] : 32'hDEAD_BEEF;
   end

   always @(posedge clk) begin
      if (pre_we[1]) rf1[pre_idx] <= pre_val;
      else if (bif1.write_en) rf1[bif1.write_reg] <= bif1.write_value;
      rd1[0] <= bif1.read_en ? rf1[bif1.read_reg] : 32'hDEAD_BEEF;
      rd1[1] <= rd1[0];
      rd1[2] <= rd1[1];
   end

   assign bif0.read_value = rd0;
   assign bif1.read_value = rd1[2];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   task automatic push(input int inst, input int kind, input logic [3:0] idx, input logic [31:0] val);
      exp_t e;
      e.kind = kind;
      e.idx  = idx;
      e.val  = val;
      if (inst == 0) exp_q0.push_back(e);
      else exp_q1.push_back(e);
   endtask

   task automatic pop_exp(input int inst, output exp_t e, output bit ok);
      ok = 1'b0;
      e.kind = -1;
      e.idx  = '0;
      e.val  = '0;
      if (inst == 0 && exp_q0.size() > 0) begin
         e = exp_q0.pop_front();
         ok = 1'b1;
      end else if (inst == 1 && exp_q1.size() > 0) begin
         e = exp_q1.pop_front();
         ok = 1'b1;
      end
   endtask

   task automatic mon(input int inst, input logic we, input logic [3:0] wr, input logic [31:0] wv,
                      input logic ts, input logic tv, input logic dn);
      exp_t e;
      bit   ok;
      if (we === 1'b1) begin
         pop_exp(inst, e, ok);
         if (!ok) check($sformatf("u%0d unexpected write r%0d", inst, wr), wv, 32'h0);
         else begin
            check($sformatf("u%0d event kind (write)", inst), 32'(K_WR), 32'(e.kind));
            check($sformatf("u%0d write_reg", inst), 32'(wr), 32'(e.idx));
            check($sformatf("u%0d write_value", inst), wv, e.val);
         end
      end
      if (ts === 1'b1) begin
         pop_exp(inst, e, ok);
         if (!ok) check($sformatf("u%0d unexpected thumb_set_en", inst), 32'(ts), 32'h0);
         else begin
            check($sformatf("u%0d event kind (thumb)", inst), 32'(K_TH), 32'(e.kind));
            check($sformatf("u%0d thumb_value", inst), 32'(tv), e.val);
         end
      end
      if (dn === 1'b1) begin
         pop_exp(inst, e, ok);
         if (!ok) check($sformatf("u%0d unexpected done", inst), 32'(dn), 32'h0);
         else begin
            check($sformatf("u%0d event kind (done)", inst), 32'(K_DN), 32'(e.kind));
            check($sformatf("u%0d done latency", inst), 32'(cyc - start_cyc[inst]), e.val);
         end
      end
   endtask

   always @(negedge clk) mon(0, bif0.write_en, bif0.write_reg, bif0.write_value,
                             bif0.thumb_set_en, bif0.thumb_value, bif0.done);
   always @(negedge clk) mon(1, bif1.write_en, bif1.write_reg, bif1.write_value,
                             bif1.thumb_set_en, bif1.thumb_value, bif1.done);

   task automatic set_reg(input int inst, input logic [3:0] idx, input logic [31:0] val);
      @(negedge clk);
      pre_idx = idx;
      pre_val = val;
      pre_we[inst] = 1'b1;
      @(negedge clk);
      pre_we[inst] = 1'b0;
   endtask

   // Called at a negedge; en is sampled on the following rising edge.
   task automatic issue(input int inst, input logic c, input logic l, input logic x,
                        input logic [23:0] off, input logic [3:0] rm);
      if (inst == 0) begin
         bif0.cond = c; bif0.link = l; bif0.exchange = x; bif0.offset = off; bif0.rm = rm;
         bif0.en = 1'b1;
      end else begin
         bif1.cond = c; bif1.link = l; bif1.exchange = x; bif1.offset = off; bif1.rm = rm;
         bif1.en = 1'b1;
      end
      start_cyc[inst] = cyc;
      $display("[TB] u%0d issue cond=%0d link=%0d exch=%0d off=%h rm=%0d", inst, c, l, x, off, rm);
      @(negedge clk);
      if (inst == 0) bif0.en = 1'b0;
      else bif1.en = 1'b0;
   endtask

   task automatic wait_done(input int inst);
      bit seen = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if ((inst == 0 && bif0.done === 1'b1) || (inst == 1 && bif1.done === 1'b1)) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) check($sformatf("u%0d done timeout", inst), 32'h0, 32'h1);
   endtask

   task automatic check_outputs_zero(input int inst);
      if (inst == 0) begin
         check("u0 idle busy/done/rd/wr/thumb/spsr",
               32'({bif0.busy, bif0.done, bif0.read_en, bif0.write_en, bif0.thumb_set_en,
                    bif0.thumb_value, bif0.write_restore_from_SPSR}), 32'h0);
         check("u0 idle read_reg/write_reg", 32'({bif0.read_reg, bif0.write_reg}), 32'h0);
         check("u0 idle write_value", bif0.write_value, 32'h0);
      end else begin
         check("u1 idle busy/done/rd/wr/thumb/spsr",
               32'({bif1.busy, bif1.done, bif1.read_en, bif1.write_en, bif1.thumb_set_en,
                    bif1.thumb_value, bif1.write_restore_from_SPSR}), 32'h0);
         check("u1 idle read_reg/write_reg", 32'({bif1.read_reg, bif1.write_reg}), 32'h0);
         check("u1 idle write_value", bif1.write_value, 32'h0);
      end
   endtask

   initial begin
      bit seen;
      pre_we[0] = 1'b0; pre_we[1] = 1'b0; pre_idx = '0; pre_val = '0;
      start_cyc[0] = 0; start_cyc[1] = 0;
      bif0.en = 0; bif0.cond = 0; bif0.link = 0; bif0.exchange = 0; bif0.offset = '0; bif0.rm = '0;
      bif1.en = 0; bif1.cond = 0; bif1.link = 0; bif1.exchange = 0; bif1.offset = '0; bif1.rm = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_outputs_zero(0);
      check_outputs_zero(1);

      // B: 0x1000 + 8 + (0x10 << 2)
      set_reg(0, 4'd15, 32'h0000_1000);
      push(0, K_WR, 4'd15, 32'h0000_1048); push(0, K_DN, 0, 32'd4);
      @(negedge clk); issue(0, 1, 0, 0, 24'h000010, 4'd0); wait_done(0);

      // BL with offset -2: LR = 0x2004, PC = 0x2000 + 8 - 8
      set_reg(0, 4'd15, 32'h0000_2000);
      push(0, K_WR, 4'd14, 32'h0000_2004); push(0, K_WR, 4'd15, 32'h0000_2000);
      push(0, K_DN, 0, 32'd5);
      @(negedge clk); issue(0, 1, 1, 0, 24'hFFFFFE, 4'd0); wait_done(0);

      // BX r3, odd then even target
      set_reg(0, 4'd3, 32'h0000_8001);
      push(0, K_WR, 4'd15, 32'h0000_8000); push(0, K_TH, 0, 32'd1); push(0, K_DN, 0, 32'd6);
      @(negedge clk); issue(0, 1, 0, 1, 24'h0, 4'd3); wait_done(0);
      set_reg(0, 4'd3, 32'h0000_8000);
      push(0, K_WR, 4'd15, 32'h0000_8000); push(0, K_TH, 0, 32'd0); push(0, K_DN, 0, 32'd6);
      @(negedge clk); issue(0, 1, 0, 1, 24'h0, 4'd3); wait_done(0);

      // Condition failed: only PC + 4 is written
      set_reg(0, 4'd15, 32'h0000_0100);
      push(0, K_WR, 4'd15, 32'h0000_0104); push(0, K_DN, 0, 32'd4);
      @(negedge clk); issue(0, 0, 1, 1, 24'h000123, 4'd5); wait_done(0);

      // BLX r14 sees the freshly written LR
      set_reg(0, 4'd15, 32'h0000_4000);
      set_reg(0, 4'd14, 32'h0000_1235);
      push(0, K_WR, 4'd14, 32'h0000_4004); push(0, K_WR, 4'd15, 32'h0000_4004);
      push(0, K_TH, 0, 32'd0); push(0, K_DN, 0, 32'd7);
      @(negedge clk); issue(0, 1, 1, 1, 24'h0, 4'd14); wait_done(0);

      // Reset during WR_LR of a BL: the LR write already presented, nothing after
      set_reg(0, 4'd15, 32'h0000_5000);
      push(0, K_WR, 4'd14, 32'h0000_5004);
      @(negedge clk); issue(0, 1, 1, 0, 24'h0, 4'd0);
      seen = 1'b0;
      for (int k = 0; k < 20; k++) begin
         if (bif0.write_en === 1'b1 && bif0.write_reg == 4'd14) begin
            seen = 1'b1;
            break;
         end
         @(negedge clk);
      end
      check("u0 reached WR_LR", 32'(seen), 32'h1);
      rst = 1'b1;
      @(negedge clk);
      check_outputs_zero(0);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      push(0, K_WR, 4'd15, 32'h0000_500C); push(0, K_DN, 0, 32'd4);
      issue(0, 1, 0, 0, 24'h000001, 4'd0); wait_done(0);

      // READ_LAT=3: wrapping target, en held during busy is ignored
      set_reg(1, 4'd15, 32'hFFFF_FFF0);
      push(1, K_WR, 4'd15, 32'h0000_0008); push(1, K_DN, 0, 32'd6);
      @(negedge clk); issue(1, 1, 0, 0, 24'h000004, 4'd0);
      bif1.en = 1'b1; bif1.cond = 1'b1; bif1.link = 1'b1; bif1.exchange = 1'b1; bif1.rm = 4'd7;
      check("u1 busy during op", 32'(bif1.busy), 32'h1);
      repeat (3) @(negedge clk);
      bif1.en = 1'b0;
      wait_done(1);
      @(negedge clk);
      check("u1 busy after done", 32'(bif1.busy), 32'h0);
      push(1, K_WR, 4'd15, 32'h0000_000C); push(1, K_DN, 0, 32'd6);
      issue(1, 1, 0, 0, 24'hFFFFFF, 4'd0); wait_done(1);

      // BX r15 at READ_LAT=3 takes the PC as the register file returns it
      push(1, K_WR, 4'd15, 32'h0000_000C); push(1, K_TH, 0, 32'd0); push(1, K_DN, 0, 32'd10);
      @(negedge clk); issue(1, 1, 0, 1, 24'h0, 4'd15); wait_done(1);

      repeat (5) @(negedge clk);
      check("u0 scoreboard drained", 32'(exp_q0.size()), 32'h0);
      check("u1 scoreboard drained", 32'(exp_q1.size()), 32'h0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
